// File: rtl/clk_ce_gen.sv
// clk_ce_gen: registered clock-enable generator for the gated TRNG sampling domain.
// Emits one ce pulse every div+1 cycles, either for a burst of burst_len pulses
// or continuously (burst_len=0) until stop. Reports busy, done and a pulse count.
// Optional macro CLK_CE_GEN_SYNC_EN: start/stop pass through a 2-flop
// synchronizer plus rising-edge detector for requests from another clock domain.
module clk_ce_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] burst_len,
    output logic             ce,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ce_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_state;
    logic             r_ce, w_ce;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [CNT_W-1:0] r_len_sh, w_len_sh;
    logic [DIV_W-1:0] r_div_sh, w_div_sh;
    logic [DIV_W-1:0] r_div_cnt, w_div_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_start;
    logic             w_stop;

`ifdef CLK_CE_GEN_SYNC_EN
    logic [1:0] r_start_sync, r_stop_sync;
    logic       r_start_d, r_stop_d;

    // Two-flop synchronizers plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_sync <= '0;
            r_stop_sync  <= '0;
            r_start_d    <= 1'b0;
            r_stop_d     <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[0], start};
            r_stop_sync  <= {r_stop_sync[0], stop};
            r_start_d    <= r_start_sync[1];
            r_stop_d     <= r_stop_sync[1];
        end
    end

    // A held request yields a single one-cycle pulse.
    assign w_start = r_start_sync[1] & ~r_start_d;
    assign w_stop  = r_stop_sync[1]  & ~r_stop_d;
`else
    assign w_start = start;
    assign w_stop  = stop;
`endif

    // Count including the pulse currently on ce; used for counting and burst end.
    assign w_cnt_inc = r_cnt + 1'b1;

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        w_state   = r_state;
        w_ce      = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_cnt     = r_cnt;
        w_len_sh  = r_len_sh;
        w_div_sh  = r_div_sh;
        w_div_cnt = r_div_cnt;
        case (r_state)
            IDLE: begin
                // Stop, alone or together with start, is a no-op here.
                if (w_start && !w_stop) begin
                    w_state   = RUN;
                    w_div_sh  = div;
                    w_len_sh  = burst_len;
                    w_cnt     = '0;
                    w_ce      = 1'b1;
                    w_busy    = 1'b1;
                    w_div_cnt = div;
                end
            end
            RUN: begin
                if (r_ce) w_cnt = w_cnt_inc;
                // Stop wins over any pulse that would be issued on this edge.
                if (w_stop || (r_ce && (r_len_sh != '0) && (w_cnt_inc == r_len_sh))) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                end else begin
                    w_busy = 1'b1;
                    if (r_div_cnt == '0) begin
                        w_ce      = 1'b1;
                        w_div_cnt = r_div_sh;
                    end else begin
                        w_div_cnt = r_div_cnt - 1'b1;
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ce      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_len_sh  <= '0;
            r_div_sh  <= '0;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_ce      <= w_ce;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_cnt     <= w_cnt;
            r_len_sh  <= w_len_sh;
            r_div_sh  <= w_div_sh;
            r_div_cnt <= w_div_cnt;
        end
    end

    assign ce     = r_ce;
    assign busy   = r_busy;
    assign done   = r_done;
    assign ce_cnt = r_cnt;

endmodule

// File: tb/tb_clk_ce_gen.sv
// tb_clk_ce_gen: self-checking bench for clk_ce_gen (default build, direct start/stop).
// Expected waveforms come from closed-form arithmetic on div, burst_len and stop timing.
module tb_clk_ce_gen;
    localparam int DIV_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] burst_len;
    logic             ce;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ce_cnt;

    int checks   = 0;
    int errors   = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    clk_ce_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .burst_len (burst_len),
        .ce        (ce),
        .busy      (busy),
        .done      (done),
        .ce_cnt    (ce_cnt)
    );

    // One run: start sampled at edge 0; stop (if s>0) driven during cycle s.
    // Pulses fall in cycles 1, 1+(d+1), ...; the run ends at cycle E, done at E+1.
    task automatic test_run(input string name, input int d, input int b, input int s,
                            input bit chg, input bit inj);
        int  L, E, e_cnt;
        bit  e_ce, e_busy, e_done;
        L = (b == 0) ? (1 << 30) : 1 + (b - 1) * (d + 1);
        E = (s > 0 && s < L) ? s : L;
        e_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b0;
        div = d[DIV_W-1:0]; burst_len = b[CNT_W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= E + 3; k++) begin
            stop  = (k == s);
            start = inj && (k <= E + 1);
            if (chg) begin
                div       = DIV_W'($urandom);
                burst_len = CNT_W'($urandom);
            end
            @(negedge clk);
            e_busy = (k <= E);
            e_done = (k == E + 1);
            e_ce   = e_busy && ((k - 1) % (d + 1) == 0);
            e_cnt  = (((k - 1 < E) ? k - 1 : E) + d) / (d + 1);
            checks++;
            if (ce !== e_ce) begin
                errors++;
                $display("FAIL %s ce cycle %0d: got %b expected %b", name, k, ce, e_ce);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, busy, e_busy);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, k, done, e_done);
            end
            checks++;
            if (ce_cnt !== e_cnt[CNT_W-1:0]) begin
                errors++;
                $display("FAIL %s ce_cnt cycle %0d: got %0d expected %0d", name, k, ce_cnt, e_cnt);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        last_cnt = e_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; div = '0; burst_len = '0;
        #12;
        checks++;
        if ({ce, busy, done} !== 3'b000 || ce_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got ce=%b busy=%b done=%b cnt=%0d expected all 0",
                     ce, busy, done, ce_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_cnt = 0;
    endtask

    task automatic test_spec_example();
        test_run("spec_example", 2, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_continuous_stop();
        test_run("continuous_stop", 0, 0, 10, 1'b0, 1'b0);
    endtask

    task automatic test_mid_change();
        @(posedge clk); #1;
        start = 1'b1; div = 8'd3; burst_len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; div = 8'd0; burst_len = 16'd1;
        repeat (2) @(posedge clk);
        // Shadowed values keep governing; the test_run below also scrambles inputs.
        repeat (30) @(posedge clk);
        test_run("mid_change", 3, 5, 0, 1'b1, 1'b0);
    endtask

    task automatic test_start_stop_idle();
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1; div = '0; burst_len = '0;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({ce, busy, done} !== 3'b000 || ce_cnt !== last_cnt[CNT_W-1:0]) begin
                errors++;
                $display("FAIL start_stop_idle cycle %0d: got ce=%b busy=%b done=%b cnt=%0d expected 0/0/0/%0d",
                         k, ce, busy, done, ce_cnt, last_cnt);
            end
        end
    endtask

    task automatic test_start_ignored();
        test_run("start_in_run", 1, 6, 0, 1'b0, 1'b1);
        test_run("start_in_run_stop", 0, 0, 7, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; div = 8'd1; burst_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ce !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got ce=%b busy=%b expected 1/1", ce, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ce, busy, done} !== 3'b000 || ce_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid: got ce=%b busy=%b done=%b cnt=%0d expected all 0",
                     ce, busy, done, ce_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_run("after_reset", 2, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int d, b, s, L;
            d = $urandom_range(0, 4);
            b = $urandom_range(0, 6);
            L = 1 + ((b > 0) ? b - 1 : 0) * (d + 1);
            if (b == 0) s = $urandom_range(1, 20);
            else        s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, L + 2);
            test_run("random", d, b, s, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_spec_example();
        test_continuous_stop();
        test_mid_change();
        test_start_stop_idle();
        test_start_ignored();
        test_start_stop_idle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
